// File: rtl/bus_seq_if.sv
// Bus-side signal bundle for bus_seq_gen: access qualifiers in, sequence data and status out.
// Handshake: a command is taken on each rising edge where acc=1 and the cycle is
// qualified (sser_n=0, ba[13:12] matches the window, br_w=1); there is no back-pressure.
interface bus_seq_if #(
  parameter int STATE_W = 6,
  parameter int CH      = 2
);
  logic               sser_n;
  logic [13:0]        ba;
  logic               br_w;
  logic               acc;
  logic [CH-1:0]      dout;
  logic               dout_oe;
  logic               locked;
  logic [STATE_W-1:0] seq_state;

  modport master (
    output sser_n, ba, br_w, acc,
    input  dout, dout_oe, locked, seq_state
  );

  modport slave (
    input  sser_n, ba, br_w, acc,
    output dout, dout_oe, locked, seq_state
  );
endinterface

// File: rtl/bus_seq_gen.sv
// Key-locked LFSR sequence generator on a bus window. Optional macro SEQ_AUTOSTEP_EN makes
// a qualified NOP step the sequence while open.
module bus_seq_gen #(
  parameter int                      STATE_W = 6,
  parameter int                      CH      = 2,
  parameter logic [STATE_W-1:0]      SEED    = 6'h01,
  parameter logic [STATE_W-1:0]      POLY    = 6'h21,
  parameter logic [CH*STATE_W-1:0]   TAP     = {6'h20, 6'h01},
  parameter logic [11:0]             KEY     = 12'hABC,
  parameter logic [1:0]              WIN     = 2'b01
) (
  input logic       clk,
  input logic       rst_n,
  bus_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_LOCK = 3'd0,
    S_K1   = 3'd1,
    S_K2   = 3'd2,
    S_K3   = 3'd3,
    S_OPEN = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [STATE_W-1:0] seq_q, seq_d;
  logic [CH-1:0]      dout_q, dout_d;
  logic               locked_q, locked_d;

  logic               qual;
  logic [3:0]         cmd;
  logic [2:0]         exp_digit;
  logic               do_step;
  logic               do_seed;
  logic               unused_ba;

  assign unused_ba = ^{bus.ba[11:8], bus.ba[3:0]};

  always_comb begin
    qual      = bus.acc & ~bus.sser_n & (bus.ba[13:12] == WIN) & bus.br_w;
    cmd       = bus.ba[7:4];
    state_d   = state_q;
    seq_d     = seq_q;
    do_step   = 1'b0;
    do_seed   = 1'b0;
    exp_digit = KEY[11:9];

    case (state_q)
      S_K1:    exp_digit = KEY[8:6];
      S_K2:    exp_digit = KEY[5:3];
      S_K3:    exp_digit = KEY[2:0];
      default: exp_digit = KEY[11:9];
    endcase

    if (qual) begin
      if (state_q == S_OPEN) begin
        // Key digits are deliberately ignored here; only RELOCK leaves OPEN.
        case (cmd)
          4'h1: do_step = 1'b1;
          4'h2: do_seed = 1'b1;
          4'h3: begin
            state_d = S_LOCK;
            do_seed = 1'b1;
          end
`ifdef SEQ_AUTOSTEP_EN
          4'h0: do_step = 1'b1;
`endif
          default: ;
        endcase
      end else if (cmd[3] && (cmd[2:0] == exp_digit)) begin
        case (state_q)
          S_LOCK:  state_d = S_K1;
          S_K1:    state_d = S_K2;
          S_K2:    state_d = S_K3;
          S_K3:    state_d = S_OPEN;
          default: state_d = S_LOCK;
        endcase
      end else begin
        state_d = S_LOCK;
      end
    end

    // An all-zero register would never leave zero, so STEP recovers it from SEED.
    if (do_seed || (do_step && (seq_q == '0))) begin
      seq_d = SEED;
    end else if (do_step) begin
      seq_d = {seq_q[STATE_W-2:0], ^(seq_q & POLY)};
    end

    locked_d = (state_d != S_OPEN);
    for (int n = 0; n < CH; n++) begin
      dout_d[n] = (state_d == S_OPEN) ? ^(seq_d & TAP[n*STATE_W +: STATE_W]) : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOCK;
      seq_q    <= SEED;
      dout_q   <= '0;
      locked_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      dout_q   <= dout_d;
      locked_q <= locked_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.locked    = locked_q;
  assign bus.seq_state = seq_q;
  assign bus.dout_oe   = ~bus.sser_n & (bus.ba[13:12] == WIN) & bus.br_w;

endmodule

// File: tb/tb_bus_seq_gen.sv
// Directed bench for bus_seq_gen: reset, unlock, stepping, qualification, relock, autostep.
module tb_bus_seq_gen;

  localparam logic [1:0] WIN = 2'b01;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bus_seq_if #(.STATE_W(6), .CH(2)) bif ();

  bus_seq_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    bif.acc    = 1'b0;
    bif.sser_n = 1'b1;
    bif.br_w   = 1'b0;
    bif.ba     = 14'h0;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic a, input logic s_n,
                       input logic rw, input logic [1:0] win);
    @(negedge clk);
    bif.acc    = a;
    bif.sser_n = s_n;
    bif.br_w   = rw;
    bif.ba     = {win, 4'h0, cmd, 4'h0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd);
    drive(cmd, 1'b1, 1'b0, 1'b1, WIN);
    tick();
    idle();
  endtask

  // scenarios
  task automatic test_reset();
    total++; if (bif.seq_state !== 6'h01) begin $display("FAIL reset_seq got=%h exp=01", bif.seq_state); bad++; end
    total++; if (bif.locked !== 1'b1) begin $display("FAIL reset_locked got=%b exp=1", bif.locked); bad++; end
    total++; if (bif.dout !== 2'b00) begin $display("FAIL reset_dout got=%b exp=00", bif.dout); bad++; end
    total++; if (bif.dout_oe !== 1'b0) begin $display("FAIL reset_oe got=%b exp=0", bif.dout_oe); bad++; end
  endtask

  task automatic test_unlock();
    logic [3:0] keys [4];
    logic       exp_lk [4];
    keys   = '{4'hD, 4'hA, 4'hF, 4'hC};
    exp_lk = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(keys[i]);
      total++;
      if (bif.locked !== exp_lk[i]) begin
        $display("FAIL unlock_locked step=%0d got=%b exp=%b", i, bif.locked, exp_lk[i]); bad++;
      end
    end
    total++; if (bif.dout !== 2'b01) begin $display("FAIL unlock_dout got=%b exp=01", bif.dout); bad++; end
    total++; if (bif.seq_state !== 6'h01) begin $display("FAIL unlock_seq got=%h exp=01", bif.seq_state); bad++; end
  endtask

  task automatic test_sequence();
    logic [5:0] exp_seq  [6];
    logic [1:0] exp_dout [6];
    exp_seq  = '{6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, 6'h3E};
    exp_dout = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 6; i++) begin
      issue(4'h1);
      total++;
      if (bif.seq_state !== exp_seq[i]) begin
        $display("FAIL step_seq n=%0d got=%h exp=%h", i, bif.seq_state, exp_seq[i]); bad++;
      end
      total++;
      if (bif.dout !== exp_dout[i]) begin
        $display("FAIL step_dout n=%0d got=%b exp=%b", i, bif.dout, exp_dout[i]); bad++;
      end
    end
  endtask

  task automatic test_qualification();
    // each row: sser_n, br_w, window, acc, expected dout_oe
    logic       s_tab  [4];
    logic       rw_tab [4];
    logic [1:0] w_tab  [4];
    logic       a_tab  [4];
    logic       oe_tab [4];
    s_tab  = '{1'b1, 1'b0, 1'b0,  1'b0};
    rw_tab = '{1'b1, 1'b0, 1'b1,  1'b1};
    w_tab  = '{WIN,  WIN,  2'b00, WIN};
    a_tab  = '{1'b1, 1'b1, 1'b1,  1'b0};
    oe_tab = '{1'b0, 1'b0, 1'b0,  1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(4'h1, a_tab[i], s_tab[i], rw_tab[i], w_tab[i]);
      #1;
      total++;
      if (bif.dout_oe !== oe_tab[i]) begin
        $display("FAIL qual_oe case=%0d got=%b exp=%b", i, bif.dout_oe, oe_tab[i]); bad++;
      end
      tick();
      idle();
      total++;
      if (bif.seq_state !== 6'h3E) begin
        $display("FAIL qual_seq case=%0d got=%h exp=3E", i, bif.seq_state); bad++;
      end
    end
  endtask

  task automatic test_key_in_open();
    issue(4'hD);
    total++; if (bif.locked !== 1'b0) begin $display("FAIL open_key_locked got=%b exp=0", bif.locked); bad++; end
    total++; if (bif.seq_state !== 6'h3E) begin $display("FAIL open_key_seq got=%h exp=3E", bif.seq_state); bad++; end
  endtask

  task automatic test_reseed();
    issue(4'h2);
    total++; if (bif.seq_state !== 6'h01) begin $display("FAIL reseed_seq got=%h exp=01", bif.seq_state); bad++; end
    total++; if (bif.dout !== 2'b01) begin $display("FAIL reseed_dout got=%b exp=01", bif.dout); bad++; end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq [3];
    exp_seq = '{6'h03, 6'h07, 6'h0F};
    drive(4'h1, 1'b1, 1'b0, 1'b1, WIN);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bif.seq_state !== exp_seq[i]) begin
        $display("FAIL b2b_seq n=%0d got=%h exp=%h", i, bif.seq_state, exp_seq[i]); bad++;
      end
    end
    idle();
  endtask

  task automatic test_relock();
    issue(4'h3);
    total++; if (bif.locked !== 1'b1) begin $display("FAIL relock_locked got=%b exp=1", bif.locked); bad++; end
    total++; if (bif.seq_state !== 6'h01) begin $display("FAIL relock_seq got=%h exp=01", bif.seq_state); bad++; end
    total++; if (bif.dout !== 2'b00) begin $display("FAIL relock_dout got=%b exp=00", bif.dout); bad++; end
  endtask

  task automatic test_wrong_key();
    issue(4'hD); issue(4'hA); issue(4'hB);
    total++; if (bif.locked !== 1'b1) begin $display("FAIL wrong_key_locked got=%b exp=1", bif.locked); bad++; end
    issue(4'h1);
    total++; if (bif.seq_state !== 6'h01) begin $display("FAIL locked_step_seq got=%h exp=01", bif.seq_state); bad++; end
    // non-key command after the first digit must restart the sequence
    issue(4'hD); issue(4'h1); issue(4'hA); issue(4'hF); issue(4'hC);
    total++; if (bif.locked !== 1'b1) begin $display("FAIL nonkey_abort_locked got=%b exp=1", bif.locked); bad++; end
    issue(4'hD); issue(4'hA); issue(4'hF); issue(4'hC);
    total++; if (bif.locked !== 1'b0) begin $display("FAIL rekey_locked got=%b exp=0", bif.locked); bad++; end
  endtask

  task automatic test_autostep();
    logic [5:0] exp_seq;
`ifdef SEQ_AUTOSTEP_EN
    exp_seq = 6'h03;
`else
    exp_seq = 6'h01;
`endif
    issue(4'h0);
    total++; if (bif.seq_state !== exp_seq) begin $display("FAIL nop_seq got=%h exp=%h", bif.seq_state, exp_seq); bad++; end
  endtask

  task automatic test_reset_mid();
    issue(4'h1); issue(4'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bif.seq_state !== 6'h01) begin $display("FAIL async_rst_seq got=%h exp=01", bif.seq_state); bad++; end
    total++; if (bif.locked !== 1'b1) begin $display("FAIL async_rst_locked got=%b exp=1", bif.locked); bad++; end
    total++; if (bif.dout !== 2'b00) begin $display("FAIL async_rst_dout got=%b exp=00", bif.dout); bad++; end
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'hD);
    issue(4'h1);
    total++; if (bif.locked !== 1'b1) begin $display("FAIL post_rst_locked got=%b exp=1", bif.locked); bad++; end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    #17;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_unlock();
    test_sequence();
    test_qualification();
    test_key_in_open();
    test_reseed();
    test_back_to_back();
    test_relock();
    test_wrong_key();
    test_autostep();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_seq_gen.md
BUS_SEQ_GEN -- requirements
Module: bus_seq_gen

Interface
REQ-001 SHALL have parameter STATE_W, default 6, sequence register width, legal 3..16.
REQ-002 SHALL have parameter CH, default 2, output data channel count, legal 1..8.
REQ-003 SHALL have parameter SEED, default 6'h01, nonzero reset/reseed value of the sequence register.
REQ-004 SHALL have parameter POLY, default 6'h21, feedback tap mask.
REQ-005 SHALL have parameter TAP, default {6'h20,6'h01}, CH*STATE_W output masks; channel n uses slice n.
REQ-006 SHALL have parameter KEY, default 12'hABC, four 3-bit unlock digits, first digit in bits [11:9].
REQ-007 SHALL have parameter WIN, default 2'b01, match value for ba[13:12].
REQ-008 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-009 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port sser_n, input, 1, active-low block select.
REQ-011 SHALL have port ba, input, 14, bus address; [13:12] window, [7:4] command nibble.
REQ-012 SHALL have port br_w, input, 1, 1 = read cycle.
REQ-013 SHALL have port acc, input, 1, access strobe, one cycle per bus access.
REQ-014 SHALL have port dout, output, CH, sequence data bits.
REQ-015 SHALL have port dout_oe, output, 1, drive enable for dout.
REQ-016 SHALL have port locked, output, 1, 1 while the unlock FSM is not OPEN.
REQ-017 SHALL have port seq_state, output, STATE_W, current sequence register (debug).

Function
REQ-018 SHALL treat a cycle as qualified when acc=1, sser_n=0, ba[13:12]=WIN and br_w=1; all other cycles hold all state.
REQ-019 SHALL decode cmd=ba[7:4] on qualified cycles: 4'h0 NOP, 4'h1 STEP, 4'h2 RESEED, 4'h3 RELOCK, 4'h8-4'hF KEY digit cmd[2:0], others NOP.
REQ-020 STEP SHALL set seq <= {seq[STATE_W-2:0], ^(seq & POLY)}; if seq==0, STEP SHALL load SEED.
REQ-021 RESEED SHALL load SEED; STEP/RESEED SHALL act only in OPEN, ignored while locked.
REQ-022 Unlock FSM states: LOCK, K1, K2, K3, OPEN; a KEY digit equal to the next expected digit advances LOCK->K1->K2->K3->OPEN.
REQ-023 A KEY digit not matching in LOCK/K1/K2/K3 SHALL return to LOCK; any non-KEY command in K1..K3 SHALL return to LOCK.
REQ-024 In OPEN, KEY digits SHALL be ignored; RELOCK SHALL go to LOCK and load SEED in the same edge.
REQ-025 dout[n] SHALL equal ^(seq & TAP slice n) in OPEN and 0 otherwise, decoded from registers only (no input-to-output path).
REQ-026 dout_oe SHALL be combinational: ~sser_n & (ba[13:12]==WIN) & br_w.
REQ-027 Command effects SHALL be visible on dout/seq_state/locked after the qualifying clock edge (latency 1).
REQ-028 acc held high for k cycles SHALL execute the command k times.

Reset
REQ-029 rst_n=0 SHALL immediately force seq=SEED, FSM=LOCK, locked=1, dout=0, regardless of clk, including mid-sequence.
REQ-030 First qualified command SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro SEQ_AUTOSTEP_EN: defined -> a qualified NOP (cmd 4'h0) in OPEN SHALL behave as STEP; undefined -> NOP SHALL hold state.

Verification
REQ-032 Reset: rst_n=0 mid-run -> seq_state=6'h01, locked=1, dout=2'b00 without a clock edge.
REQ-033 Unlock: qualified cmds 4'hD,4'hA,4'hF,4'hC -> locked=0 after 4th edge, dout=2'b01.
REQ-034 Sequence: from unlocked seq=6'h01, six STEPs -> seq_state 03,07,0F,1F,3F,3E; dout after 5th = 2'b11, after 6th = 2'b10.
REQ-035 Wrong key: 4'hD,4'hA,4'hB -> FSM LOCK; then 4'hD,4'hA,4'hF,4'hC -> locked=0; STEP while locked -> seq unchanged.
REQ-036 Qualification: STEP with sser_n=1, or br_w=0, or ba[13:12]=2'b00 -> no state change, dout_oe=0 in each case.
REQ-037 Macro: OPEN, seq=6'h01, qualified NOP -> seq_state=6'h03 with SEQ_AUTOSTEP_EN, 6'h01 without.
